// File: rtl/axil_ipic_bridge_if.sv
// AXI4-Lite slave-side and IPIC bus bundles for the Ethernet register bridge.
// Bridge uses axil_if.slave and ipic_if.master; the far ends use the opposite modports.
interface axil_if #(
    parameter int C_ADDR_WIDTH = 12
);
    logic [C_ADDR_WIDTH-1:0] s_axi_awaddr;
    logic                    s_axi_awvalid;
    logic                    s_axi_awready;
    logic [31:0]             s_axi_wdata;
    logic [3:0]              s_axi_wstrb;
    logic                    s_axi_wvalid;
    logic                    s_axi_wready;
    logic [1:0]              s_axi_bresp;
    logic                    s_axi_bvalid;
    logic                    s_axi_bready;
    logic [C_ADDR_WIDTH-1:0] s_axi_araddr;
    logic                    s_axi_arvalid;
    logic                    s_axi_arready;
    logic [31:0]             s_axi_rdata;
    logic [1:0]              s_axi_rresp;
    logic                    s_axi_rvalid;
    logic                    s_axi_rready;

    modport master (
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
               s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

    modport slave (
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
               s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );
endinterface

interface ipic_if #(
    parameter int C_ADDR_WIDTH = 12
);
    logic [C_ADDR_WIDTH-1:0] bus2ip_addr;
    logic                    bus2ip_cs;
    logic                    bus2ip_rdce;
    logic                    bus2ip_wrce;
    logic [31:0]             bus2ip_data;
    logic [3:0]              bus2ip_be;
    logic                    ip2bus_rdack;
    logic                    ip2bus_wrack;
    logic                    ip2bus_error;
    logic [31:0]             ip2bus_data;

    modport master (
        output bus2ip_addr, bus2ip_cs, bus2ip_rdce, bus2ip_wrce, bus2ip_data, bus2ip_be,
        input  ip2bus_rdack, ip2bus_wrack, ip2bus_error, ip2bus_data
    );

    modport slave (
        input  bus2ip_addr, bus2ip_cs, bus2ip_rdce, bus2ip_wrce, bus2ip_data, bus2ip_be,
        output ip2bus_rdack, ip2bus_wrack, ip2bus_error, ip2bus_data
    );
endinterface

// File: rtl/axil_ipic_bridge.sv
// AXI4-Lite slave to IPIC master bridge: one transaction at a time, held strobes,
// SLVERR when no IPIC slave acks within C_TIMEOUT strobe cycles.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | accepting AR or AW+W, round-robin when both are eligible
// READ    | cs/rdce held, waiting for rdack or timeout
// WRITE   | cs/wrce held, waiting for wrack or timeout
// RD_RESP | rvalid held until rready
// WR_RESP | bvalid held until bready
module axil_ipic_bridge #(
    parameter int C_ADDR_WIDTH = 12,
    parameter int C_TIMEOUT    = 32
) (
    input  logic   bus2ip_clk,
    input  logic   bus2ip_reset,
    axil_if.slave  s_axi,
    ipic_if.master ipic
);

    localparam int TW = (C_TIMEOUT > 2) ? $clog2(C_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LOAD = TW'(C_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_RD_RESP,
        S_WR_RESP
    } state_t;

    state_t        state;
    logic          last_was_read;
    logic [TW-1:0] tmo_cnt;
    logic          rd_elig;
    logic          wr_elig;
    logic          rd_grant;
    logic          wr_grant;

    assign rd_elig  = s_axi.s_axi_arvalid;
    assign wr_elig  = s_axi.s_axi_awvalid & s_axi.s_axi_wvalid;
    // Under contention the side that did not go last wins.
    assign rd_grant = rd_elig & (~wr_elig | ~last_was_read);
    assign wr_grant = wr_elig & (~rd_elig | last_was_read);

    assign s_axi.s_axi_arready = (state == S_IDLE) & rd_grant;
    assign s_axi.s_axi_awready = (state == S_IDLE) & wr_grant;
    assign s_axi.s_axi_wready  = (state == S_IDLE) & wr_grant;

    always_ff @(posedge bus2ip_clk) begin
        if (bus2ip_reset) begin
            state              <= S_IDLE;
            last_was_read      <= 1'b0;
            tmo_cnt            <= '0;
            s_axi.s_axi_rdata  <= '0;
            s_axi.s_axi_rresp  <= 2'b00;
            s_axi.s_axi_rvalid <= 1'b0;
            s_axi.s_axi_bresp  <= 2'b00;
            s_axi.s_axi_bvalid <= 1'b0;
            ipic.bus2ip_addr   <= '0;
            ipic.bus2ip_data   <= '0;
            ipic.bus2ip_be     <= '0;
            ipic.bus2ip_cs     <= 1'b0;
            ipic.bus2ip_rdce   <= 1'b0;
            ipic.bus2ip_wrce   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rd_grant) begin
                        ipic.bus2ip_addr <= s_axi.s_axi_araddr;
                        ipic.bus2ip_cs   <= 1'b1;
                        ipic.bus2ip_rdce <= 1'b1;
                        tmo_cnt          <= TMO_LOAD;
                        last_was_read    <= 1'b1;
                        state            <= S_READ;
                    end else if (wr_grant) begin
                        ipic.bus2ip_addr <= s_axi.s_axi_awaddr;
                        ipic.bus2ip_data <= s_axi.s_axi_wdata;
                        ipic.bus2ip_be   <= s_axi.s_axi_wstrb;
                        ipic.bus2ip_cs   <= 1'b1;
                        ipic.bus2ip_wrce <= 1'b1;
                        tmo_cnt          <= TMO_LOAD;
                        last_was_read    <= 1'b0;
                        state            <= S_WRITE;
                    end
                end
                S_READ: begin
                    // An ack in the terminal-count cycle still wins over the abort.
                    if (ipic.ip2bus_rdack) begin
                        s_axi.s_axi_rdata  <= ipic.ip2bus_data;
                        s_axi.s_axi_rresp  <= ipic.ip2bus_error ? 2'b10 : 2'b00;
                        s_axi.s_axi_rvalid <= 1'b1;
                        ipic.bus2ip_cs     <= 1'b0;
                        ipic.bus2ip_rdce   <= 1'b0;
                        state              <= S_RD_RESP;
                    end else if (tmo_cnt == '0) begin
                        s_axi.s_axi_rdata  <= '0;
                        s_axi.s_axi_rresp  <= 2'b10;
                        s_axi.s_axi_rvalid <= 1'b1;
                        ipic.bus2ip_cs     <= 1'b0;
                        ipic.bus2ip_rdce   <= 1'b0;
                        state              <= S_RD_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
                end
                S_WRITE: begin
                    if (ipic.ip2bus_wrack || tmo_cnt == '0) begin
                        s_axi.s_axi_bresp  <= (ipic.ip2bus_wrack && !ipic.ip2bus_error)
                                              ? 2'b00 : 2'b10;
                        s_axi.s_axi_bvalid <= 1'b1;
                        ipic.bus2ip_cs     <= 1'b0;
                        ipic.bus2ip_wrce   <= 1'b0;
                        state              <= S_WR_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
                end
                S_RD_RESP: begin
                    if (s_axi.s_axi_rready) begin
                        s_axi.s_axi_rvalid <= 1'b0;
                        state              <= S_IDLE;
                    end
                end
                S_WR_RESP: begin
                    if (s_axi.s_axi_bready) begin
                        s_axi.s_axi_bvalid <= 1'b0;
                        state              <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_ipic_bridge.sv
// Directed bench for axil_ipic_bridge: read/write paths, timeout, arbitration,
// response back-pressure and mid-transaction reset.
module tb_axil_ipic_bridge;

    logic bus2ip_clk = 1'b0;
    logic bus2ip_reset;
    int   checks = 0;
    int   errors = 0;
    int   overlap = 0;
    int   n;
    int   n_rdce;
    int   n_rvalid;

    axil_if #(.C_ADDR_WIDTH(12)) axi ();
    ipic_if #(.C_ADDR_WIDTH(12)) ip ();

    axil_ipic_bridge #(.C_ADDR_WIDTH(12), .C_TIMEOUT(32)) dut (
        .bus2ip_clk   (bus2ip_clk),
        .bus2ip_reset (bus2ip_reset),
        .s_axi        (axi),
        .ipic         (ip)
    );

    always #5 bus2ip_clk = ~bus2ip_clk;

    always @(negedge bus2ip_clk) if (ip.bus2ip_rdce && ip.bus2ip_wrce) overlap++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge bus2ip_clk);
        #1;
    endtask

    initial begin
        bus2ip_reset = 1'b1;
        axi.s_axi_awaddr = '0; axi.s_axi_awvalid = 0; axi.s_axi_wdata = '0;
        axi.s_axi_wstrb = '0;  axi.s_axi_wvalid = 0;  axi.s_axi_bready = 0;
        axi.s_axi_araddr = '0; axi.s_axi_arvalid = 0; axi.s_axi_rready = 0;
        ip.ip2bus_rdack = 0; ip.ip2bus_wrack = 0; ip.ip2bus_error = 0; ip.ip2bus_data = '0;
        tick(); tick();

        // reset state
        chk("rst_ready", {axi.s_axi_arready, axi.s_axi_awready, axi.s_axi_wready}, 0);
        chk("rst_valid", {axi.s_axi_rvalid, axi.s_axi_bvalid}, 0);
        chk("rst_resp", {axi.s_axi_rresp, axi.s_axi_bresp}, 0);
        chk("rst_rdata", axi.s_axi_rdata, 0);
        chk("rst_ipic", {ip.bus2ip_addr, ip.bus2ip_data, ip.bus2ip_be,
                         ip.bus2ip_cs, ip.bus2ip_rdce, ip.bus2ip_wrce}, 0);
        bus2ip_reset = 1'b0;

        // read 0x404, rdack on third strobe cycle
        axi.s_axi_araddr = 12'h404; axi.s_axi_arvalid = 1; #1;
        chk("t1_arready", axi.s_axi_arready, 1);
        tick(); axi.s_axi_arvalid = 0;
        chk("t1_strobe1", {ip.bus2ip_cs, ip.bus2ip_rdce, ip.bus2ip_wrce}, 3'b110);
        chk("t1_addr", ip.bus2ip_addr, 12'h404);
        tick();
        chk("t1_rdce2", ip.bus2ip_rdce, 1);
        tick();
        chk("t1_rdce3", ip.bus2ip_rdce, 1);
        chk("t1_novalid", axi.s_axi_rvalid, 0);
        ip.ip2bus_rdack = 1; ip.ip2bus_data = 32'hDEADBEEF;
        tick(); ip.ip2bus_rdack = 0; ip.ip2bus_data = '0;
        chk("t1_strobe_off", {ip.bus2ip_cs, ip.bus2ip_rdce}, 0);
        chk("t1_rvalid", axi.s_axi_rvalid, 1);
        chk("t1_rdata", axi.s_axi_rdata, 32'hDEADBEEF);
        chk("t1_rresp", axi.s_axi_rresp, 2'b00);
        axi.s_axi_rready = 1;
        tick(); axi.s_axi_rready = 0;
        chk("t1_rvalid_off", axi.s_axi_rvalid, 0);

        // write 0x600, W arrives two cycles after AW
        axi.s_axi_awaddr = 12'h600; axi.s_axi_awvalid = 1; #1;
        chk("t2_aw_only_T", {axi.s_axi_awready, axi.s_axi_wready}, 0);
        tick(); #1;
        chk("t2_aw_only_T1", {axi.s_axi_awready, axi.s_axi_wready}, 0);
        tick();
        axi.s_axi_wdata = 32'h12345678; axi.s_axi_wstrb = 4'hF; axi.s_axi_wvalid = 1; #1;
        chk("t2_ready_T2", {axi.s_axi_awready, axi.s_axi_wready}, 2'b11);
        tick(); axi.s_axi_awvalid = 0; axi.s_axi_wvalid = 0;
        chk("t2_strobe", {ip.bus2ip_cs, ip.bus2ip_rdce, ip.bus2ip_wrce}, 3'b101);
        chk("t2_addr", ip.bus2ip_addr, 12'h600);
        chk("t2_data", ip.bus2ip_data, 32'h12345678);
        chk("t2_be", ip.bus2ip_be, 4'hF);
        ip.ip2bus_wrack = 1;
        tick(); ip.ip2bus_wrack = 0;
        chk("t2_bvalid", {axi.s_axi_bvalid, ip.bus2ip_wrce}, 2'b10);
        chk("t2_bresp", axi.s_axi_bresp, 2'b00);
        axi.s_axi_bready = 1;
        tick(); axi.s_axi_bready = 0;
        chk("t2_bvalid_off", axi.s_axi_bvalid, 0);

        // read 0x100, nobody acks -> timeout
        axi.s_axi_araddr = 12'h100; axi.s_axi_arvalid = 1;
        tick(); axi.s_axi_arvalid = 0;
        n = 1; n_rdce = 0;
        while (!axi.s_axi_rvalid && n < 64) begin
            n_rdce += int'(ip.bus2ip_rdce);
            tick();
            n++;
        end
        chk("t3_latency", n, 33);
        chk("t3_rdce_cycles", n_rdce, 32);
        chk("t3_rresp", axi.s_axi_rresp, 2'b10);
        chk("t3_rdata", axi.s_axi_rdata, 0);
        chk("t3_strobe_off", {ip.bus2ip_cs, ip.bus2ip_rdce}, 0);
        axi.s_axi_rready = 1;
        tick(); axi.s_axi_rready = 0;

        // contention right after reset: read first, then write (with error)
        bus2ip_reset = 1; tick(); bus2ip_reset = 0;
        axi.s_axi_araddr = 12'h010; axi.s_axi_arvalid = 1;
        axi.s_axi_awaddr = 12'h020; axi.s_axi_awvalid = 1;
        axi.s_axi_wdata = 32'hCAFE0001; axi.s_axi_wstrb = 4'h3; axi.s_axi_wvalid = 1; #1;
        chk("t4_grant_rd", {axi.s_axi_arready, axi.s_axi_awready, axi.s_axi_wready}, 3'b100);
        tick(); axi.s_axi_arvalid = 0; #1;
        chk("t4_busy_noready", axi.s_axi_awready, 0);
        chk("t4_rd_strobe", {ip.bus2ip_rdce, ip.bus2ip_wrce, ip.bus2ip_addr}, {2'b10, 12'h010});
        ip.ip2bus_rdack = 1; ip.ip2bus_data = 32'h11112222;
        tick(); ip.ip2bus_rdack = 0;
        chk("t4_rdata", {axi.s_axi_rvalid, axi.s_axi_rdata}, {1'b1, 32'h11112222});
        axi.s_axi_rready = 1;
        tick(); axi.s_axi_rready = 0; #1;
        chk("t4_grant_wr", {axi.s_axi_awready, axi.s_axi_wready}, 2'b11);
        tick(); axi.s_axi_awvalid = 0; axi.s_axi_wvalid = 0;
        chk("t4_wr_strobe", {ip.bus2ip_rdce, ip.bus2ip_wrce, ip.bus2ip_addr}, {2'b01, 12'h020});
        chk("t4_wr_data", {ip.bus2ip_data, ip.bus2ip_be}, {32'hCAFE0001, 4'h3});
        ip.ip2bus_wrack = 1; ip.ip2bus_error = 1;
        tick(); ip.ip2bus_wrack = 0; ip.ip2bus_error = 0;
        chk("t5_bresp_err", {axi.s_axi_bvalid, axi.s_axi_bresp}, 3'b110);
        axi.s_axi_bready = 1;
        tick(); axi.s_axi_bready = 0;

        // lone read, then contention must go to the write
        axi.s_axi_araddr = 12'h030; axi.s_axi_arvalid = 1;
        tick(); axi.s_axi_arvalid = 0;
        ip.ip2bus_rdack = 1; ip.ip2bus_data = 32'h5;
        tick(); ip.ip2bus_rdack = 0;
        axi.s_axi_rready = 1;
        tick(); axi.s_axi_rready = 0;
        axi.s_axi_arvalid = 1; axi.s_axi_awvalid = 1; axi.s_axi_wvalid = 1; #1;
        chk("t4_rr_write", {axi.s_axi_arready, axi.s_axi_awready}, 2'b01);
        tick(); axi.s_axi_arvalid = 0; axi.s_axi_awvalid = 0; axi.s_axi_wvalid = 0;
        chk("t4_rr_wrce", ip.bus2ip_wrce, 1);
        ip.ip2bus_wrack = 1;
        tick(); ip.ip2bus_wrack = 0;
        axi.s_axi_bready = 1;
        tick(); axi.s_axi_bready = 0;

        // rready held low 5 cycles with another read pending
        axi.s_axi_araddr = 12'h404; axi.s_axi_arvalid = 1;
        tick(); axi.s_axi_araddr = 12'h408;
        ip.ip2bus_rdack = 1; ip.ip2bus_error = 1; ip.ip2bus_data = 32'h0BADF00D;
        tick(); ip.ip2bus_rdack = 0; ip.ip2bus_error = 0; ip.ip2bus_data = '0;
        for (int i = 0; i < 5; i++) begin
            chk("t5_hold", {axi.s_axi_rvalid, axi.s_axi_rdata, axi.s_axi_rresp, axi.s_axi_arready},
                {1'b1, 32'h0BADF00D, 2'b10, 1'b0});
            tick();
        end
        axi.s_axi_rready = 1; axi.s_axi_arvalid = 0;
        tick(); axi.s_axi_rready = 0;
        chk("t5_release", axi.s_axi_rvalid, 0);

        // reset during READ
        axi.s_axi_araddr = 12'h444; axi.s_axi_arvalid = 1;
        tick(); axi.s_axi_arvalid = 0;
        chk("t6_in_read", ip.bus2ip_rdce, 1);
        bus2ip_reset = 1;
        tick();
        chk("t6_outs_zero", {ip.bus2ip_addr, ip.bus2ip_data, ip.bus2ip_be, ip.bus2ip_cs,
                             ip.bus2ip_rdce, ip.bus2ip_wrce, axi.s_axi_rvalid, axi.s_axi_bvalid,
                             axi.s_axi_rdata, axi.s_axi_rresp, axi.s_axi_bresp}, 0);
        bus2ip_reset = 0;
        ip.ip2bus_rdack = 1; ip.ip2bus_data = 32'hFF;
        tick(); ip.ip2bus_rdack = 0; ip.ip2bus_data = '0;
        n_rvalid = 0;
        for (int i = 0; i < 5; i++) begin
            n_rvalid += int'(axi.s_axi_rvalid);
            tick();
        end
        chk("t6_no_rvalid", n_rvalid, 0);
        axi.s_axi_araddr = 12'h404; axi.s_axi_arvalid = 1;
        tick(); axi.s_axi_arvalid = 0;
        ip.ip2bus_rdack = 1; ip.ip2bus_data = 32'h600DCAFE;
        tick(); ip.ip2bus_rdack = 0;
        chk("t6_after", {axi.s_axi_rvalid, axi.s_axi_rdata, axi.s_axi_rresp},
            {1'b1, 32'h600DCAFE, 2'b00});
        axi.s_axi_rready = 1;
        tick(); axi.s_axi_rready = 0;

        chk("rdce_wrce_overlap", overlap, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
